uart_cmd_parser: RTL
====================

Name: uart_cmd_parser

Overview:
- Sits directly downstream of the UART receive path and consumes its byte stream: one byte per single-cycle valid strobe.
- Assembles fixed 5-byte command frames: HEADER, CMD, ADDR, DATA, CSUM.
- Validates each frame's checksum and an inter-byte timeout.
- Presents each good frame as one-cycle command strobe with held command fields. Reports bad frames through an error strobe and code.

Parameters:
- HEADER, 8'hAA, frame start byte.
- TIMEOUT_CYCLES, 24000, max clk_in cycles allowed between bytes inside a frame (2 ms at 12 MHz); must be >= 2.
- CNT_W, 15, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk_in  input  1  system clock (12 MHz)
- rst_n_in  input  1  reset, synchronous, active low
- rx_data_valid  input  1  single-cycle strobe; rx_data_in is valid this cycle
- rx_data_in  input  8  received byte
- cmd_valid  output  1  one-cycle pulse on a good frame
- cmd_code  output  8  CMD byte of last good frame
- cmd_addr  output  8  ADDR byte of last good frame
- cmd_data  output  8  DATA byte of last good frame
- frame_err  output  1  one-cycle pulse on a rejected frame
- err_code  output  2  cause of last rejection: 2'b01 checksum, 2'b10 timeout; 2'b00 after reset
- busy  output  1  high while state != IDLE
- good_cnt  output  8  count of good frames, saturates at 8'hFF

Behaviour:
- Reset (sampled on a clk_in rising edge with rst_n_in=0):
  - State goes to IDLE.
  - All outputs go to 0: cmd_valid, frame_err, busy, cmd_code, cmd_addr, cmd_data, err_code, good_cnt.
  - Internal byte registers and timeout counter are cleared.
  - Reset mid-frame discards the partial frame; no err pulse is produced.
- States: IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_CSUM.
- IDLE:
  - A byte equal to HEADER moves the FSM to GET_CMD.
  - Any other byte is silently discarded; no frame_err.
- GET_CMD, GET_ADDR, GET_DATA:
  - A byte is latched into the internal register for that field, and the FSM advances to the next state.
  - A byte equal to HEADER is treated as ordinary data; there is no resynchronisation.
- GET_CSUM:
  - On a byte, compare it with (CMD+ADDR+DATA) mod 256, using an 8-bit sum with carries discarded.
  - Match: on the next edge, cmd_valid=1 for exactly one cycle. cmd_code/addr/data update in that same cycle and hold until the next good frame. good_cnt increments unless it is already 8'hFF.
  - Mismatch: frame_err=1 for one cycle and err_code=2'b01. cmd_* are unchanged.
  - Either way, return to IDLE.
- Latency: cmd_valid or frame_err is asserted on the first clk_in edge after the cycle in which the CSUM byte strobe is present.
- Timeout:
  - The counter is cleared on entry to GET_CMD and on every accepted byte.
  - The counter increments each cycle in a non-IDLE state with no strobe.
  - When the counter reaches TIMEOUT_CYCLES-1 without a byte: return to IDLE, frame_err=1 for one cycle, err_code=2'b10.
  - The timeout pulse is asserted TIMEOUT_CYCLES cycles after the last accepted byte.
- Simultaneous byte strobe and timeout expiry: the byte wins and no timeout is raised.
- A byte arriving in the same cycle that the FSM returns to IDLE is evaluated by IDLE rules on the following edge only if its strobe is present then. Strobes are single-cycle, so a byte coincident with the CSUM decision cycle is not possible. The upstream receiver guarantees at least 10 bit times between strobes.
- busy is registered: high from the edge accepting HEADER until the edge that returns the FSM to IDLE.
- cmd_valid and frame_err are never both high. Both are 0 in every cycle not described above.
- err_code holds its value until the next error.

Test Plan:
- Reset, then bytes AA 01 10 5A 6B spaced 1250 cycles apart -> one cmd_valid pulse; cmd_code=01, cmd_addr=10, cmd_data=5A, good_cnt=1, frame_err never asserted.
- Bytes AA 01 10 5A 6C -> frame_err pulse, err_code=01, cmd_* keep prior values, good_cnt unchanged.
- Bytes 55 00 FF then AA 02 03 04 09 -> the first three bytes are ignored with busy=0; the following frame gives cmd_valid with cmd_code=02, cmd_addr=03, cmd_data=04. Also verify wrap: AA FF FF 03 01 accepted, since FF+FF+03=0x201 mod 256 = 01.
- Bytes AA 01, then idle -> frame_err exactly TIMEOUT_CYCLES cycles after the 01 strobe, err_code=10, busy drops the same edge. Next, a byte strobe placed exactly on the expiry cycle -> accepted, no error.
- Drive rst_n_in low for one cycle after AA 01 10 -> all outputs 0. A following full good frame is accepted normally.
- Send 256 good frames -> good_cnt reaches FF and stays FF on frame 256; cmd_valid still pulses each frame.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// Assembles 5-byte HEADER/CMD/ADDR/DATA/CSUM frames from the UART receive byte stream,
// checks the 8-bit checksum and the inter-byte timeout, and reports good and bad frames.
module uart_cmd_parser #(
  parameter logic [7:0]  HEADER         = 8'hAA,
  parameter int unsigned TIMEOUT_CYCLES = 24000,
  parameter int unsigned CNT_W          = 15
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       rx_data_valid,
  input  logic [7:0] rx_data_in,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic [7:0] cmd_addr,
  output logic [7:0] cmd_data,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy,
  output logic [7:0] good_cnt
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_GET_CMD  = 3'd1;
  localparam logic [2:0] S_GET_ADDR = 3'd2;
  localparam logic [2:0] S_GET_DATA = 3'd3;
  localparam logic [2:0] S_GET_CSUM = 3'd4;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CSUM = 2'b01;
  localparam logic [1:0] ERR_TOUT = 2'b10;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic [7:0]       f_cmd_q, f_cmd_d;
  logic [7:0]       f_addr_q, f_addr_d;
  logic [7:0]       f_data_q, f_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             frame_err_q, frame_err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [7:0]       cmd_code_q, cmd_code_d;
  logic [7:0]       cmd_addr_q, cmd_addr_d;
  logic [7:0]       cmd_data_q, cmd_data_d;
  logic [7:0]       good_cnt_q, good_cnt_d;
  logic [7:0]       csum;
  logic             expired;

  // Carries out of bit 7 are discarded by the 8-bit result width.
  assign csum    = f_cmd_q + f_addr_q + f_data_q;
  assign expired = (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    f_cmd_d     = f_cmd_q;
    f_addr_d    = f_addr_q;
    f_data_d    = f_data_q;
    cnt_d       = cnt_q;
    cmd_valid_d = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    cmd_code_d  = cmd_code_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_data_d  = cmd_data_q;
    good_cnt_d  = good_cnt_q;

    if (state_q == S_IDLE) begin
      cnt_d = '0;
      if (rx_data_valid && (rx_data_in == HEADER)) begin
        state_d = S_GET_CMD;
      end
    end else if (rx_data_valid) begin
      // An arriving byte always beats a coincident timeout expiry.
      cnt_d = '0;
      case (state_q)
        S_GET_CMD: begin
          f_cmd_d = rx_data_in;
          state_d = S_GET_ADDR;
        end
        S_GET_ADDR: begin
          f_addr_d = rx_data_in;
          state_d  = S_GET_DATA;
        end
        S_GET_DATA: begin
          f_data_d = rx_data_in;
          state_d  = S_GET_CSUM;
        end
        default: begin
          state_d = S_IDLE;
          if (rx_data_in == csum) begin
            cmd_valid_d = 1'b1;
            cmd_code_d  = f_cmd_q;
            cmd_addr_d  = f_addr_q;
            cmd_data_d  = f_data_q;
            if (good_cnt_q != 8'hFF) begin
              good_cnt_d = good_cnt_q + 8'd1;
            end
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CSUM;
          end
        end
      endcase
    end else if (expired) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      frame_err_d = 1'b1;
      err_code_d  = ERR_TOUT;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q     <= S_IDLE;
      f_cmd_q     <= '0;
      f_addr_q    <= '0;
      f_data_q    <= '0;
      cnt_q       <= '0;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      cmd_code_q  <= '0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
      good_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      f_cmd_q     <= f_cmd_d;
      f_addr_q    <= f_addr_d;
      f_data_q    <= f_data_d;
      cnt_q       <= cnt_d;
      cmd_valid_q <= cmd_valid_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      cmd_code_q  <= cmd_code_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_data_q  <= cmd_data_d;
      good_cnt_q  <= good_cnt_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign cmd_code  = cmd_code_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_data  = cmd_data_q;
  assign good_cnt  = good_cnt_q;
  assign busy      = (state_q != S_IDLE);

endmodule
